// File: rtl/arduino_packet_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arduino_packet_rx_pkg
//  Purpose  : Shared definitions for the Arduino block-update receiver:
//             GPIO bus field positions, grid size and FSM state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package arduino_packet_rx_pkg;

  // 10-bit GPIO word layout: [9:6]=X, [5:2]=Y, [1:0]=VALUE
  localparam int BUS_W = 10;
  localparam int X_MSB = 9;
  localparam int X_LSB = 6;
  localparam int Y_MSB = 5;
  localparam int Y_LSB = 2;
  localparam int V_MSB = 1;
  localparam int V_LSB = 0;

  // 16x16 block memory, addressed by an 8-bit sweep index {x, y}
  localparam int GRID_ENTRIES = 256;
  localparam int IDX_W        = 8;

  typedef enum logic [2:0] {
    ST_SWEEP    = 3'd0,
    ST_IDLE     = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_COMMIT   = 3'd3,
    ST_WAIT_LOW = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/arduino_packet_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : arduino_packet_rx_if
//  Purpose  : Bundles the GPIO-side inputs and block-memory write-port
//             outputs of the Arduino receiver.
//  Ports    : master - drives DATA_IN/ENABLE_IN/CLEAR_IN, observes outputs
//             slave  - the receiver: consumes the GPIO inputs, drives
//                      X_COORD/Y_COORD/VALUE/W_EN/BUSY/DROP_CNT
//  Revision : 1.0 - initial release
// ============================================================================
interface arduino_packet_rx_if #(
  parameter int DROP_W = 8
);
  import arduino_packet_rx_pkg::*;

  logic [BUS_W-1:0]  DATA_IN;
  logic              ENABLE_IN;
  logic              CLEAR_IN;
  logic [3:0]        X_COORD;
  logic [3:0]        Y_COORD;
  logic [1:0]        VALUE;
  logic              W_EN;
  logic              BUSY;
  logic [DROP_W-1:0] DROP_CNT;

  modport master (
    output DATA_IN, ENABLE_IN, CLEAR_IN,
    input  X_COORD, Y_COORD, VALUE, W_EN, BUSY, DROP_CNT
  );

  modport slave (
    input  DATA_IN, ENABLE_IN, CLEAR_IN,
    output X_COORD, Y_COORD, VALUE, W_EN, BUSY, DROP_CNT
  );

endinterface
`default_nettype wire

// File: rtl/arduino_packet_rx_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : Two-flop synchroniser for asynchronous inputs, per-bit.
//  Ports    : clk_i  - destination clock
//             rst_ni - asynchronous active-low reset (both stages to 0)
//             d_i    - asynchronous input, WIDTH bits
//             q_o    - synchronised output, WIDTH bits
//  Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/arduino_packet_rx.sv
`default_nettype none
// ============================================================================
//  Module   : arduino_packet_rx
//  Purpose  : Receives block-update words from the Arduino GPIO bus and turns
//             each accepted strobe into one write of (x, y, value) into the
//             16x16 block memory. Clears the whole memory after reset and on
//             a CLEAR_IN rising edge.
//  Ports    : CLOCK_50 - system clock, posedge
//             RESET_N  - asynchronous active-low reset
//             bus      - slave side: DATA_IN/ENABLE_IN/CLEAR_IN in,
//                        X_COORD/Y_COORD/VALUE/W_EN/BUSY/DROP_CNT out
//  Revision : 1.0 - initial release
// ============================================================================
module arduino_packet_rx
  import arduino_packet_rx_pkg::*;
#(
  parameter int         STABLE_CYCLES = 4,
  parameter logic [1:0] CLEAR_VALUE   = 2'b00,
  parameter int         DROP_W        = 8
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  arduino_packet_rx_if.slave bus
);

  localparam int              CNT_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(GRID_ENTRIES - 1);

  // Synchronised inputs
  logic [BUS_W-1:0] data_s;
  logic             en_s;
  logic             clr_s;

  sync_2ff #(.WIDTH(BUS_W)) u_sync_data (.clk_i(CLOCK_50), .rst_ni(RESET_N), .d_i(bus.DATA_IN),   .q_o(data_s));
  sync_2ff #(.WIDTH(1))     u_sync_en   (.clk_i(CLOCK_50), .rst_ni(RESET_N), .d_i(bus.ENABLE_IN), .q_o(en_s));
  sync_2ff #(.WIDTH(1))     u_sync_clr  (.clk_i(CLOCK_50), .rst_ni(RESET_N), .d_i(bus.CLEAR_IN),  .q_o(clr_s));

  logic en_prev_q, clr_prev_q;
  logic en_rise, clr_rise;

  assign en_rise  = en_s  & ~en_prev_q;
  assign clr_rise = clr_s & ~clr_prev_q;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [BUS_W-1:0]  cap_q,   cap_d;
  logic [DROP_W-1:0] drop_q,  drop_d;
  logic [3:0]        x_q,     x_d;
  logic [3:0]        y_q,     y_d;
  logic [1:0]        v_q,     v_d;
  logic              wen_q,   wen_d;
  logic              busy_q,  busy_d;
  logic              drop_inc;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_SWEEP;
      idx_q      <= '0;
      cnt_q      <= '0;
      cap_q      <= '0;
      drop_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      v_q        <= '0;
      wen_q      <= 1'b0;
      busy_q     <= 1'b1;
      en_prev_q  <= 1'b0;
      clr_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      cap_q      <= cap_d;
      drop_q     <= drop_d;
      x_q        <= x_d;
      y_q        <= y_d;
      v_q        <= v_d;
      wen_q      <= wen_d;
      busy_q     <= busy_d;
      en_prev_q  <= en_s;
      clr_prev_q <= clr_s;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    cap_d    = cap_q;
    x_d      = x_q;
    y_d      = y_q;
    v_d      = v_q;
    wen_d    = 1'b0;
    drop_inc = 1'b0;

    case (state_q)
      ST_SWEEP: begin
        // CLEAR and strobes are deliberately ignored until all 256 entries are written
        wen_d = 1'b1;
        x_d   = idx_q[7:4];
        y_d   = idx_q[3:0];
        v_d   = CLEAR_VALUE;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          // A strobe already high must not be taken as a fresh word
          state_d = en_s ? ST_WAIT_LOW : ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (clr_rise) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
        end else if (en_rise) begin
          cap_d   = data_s;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!en_s || clr_rise) begin
          drop_inc = 1'b1;
          idx_d    = '0;
          state_d  = clr_rise ? ST_SWEEP : ST_IDLE;
        end else if (data_s != cap_q) begin
          // Data still moving: restart the stability window on the new word
          cap_d = data_s;
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_COMMIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_COMMIT: begin
        wen_d = 1'b1;
        x_d   = cap_q[X_MSB:X_LSB];
        y_d   = cap_q[Y_MSB:Y_LSB];
        v_d   = cap_q[V_MSB:V_LSB];
        if (clr_rise) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
        end else begin
          state_d = ST_WAIT_LOW;
        end
      end
      ST_WAIT_LOW: begin
        if (clr_rise) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
        end else if (!en_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_SWEEP;
        idx_d   = '0;
      end
    endcase

    // BUSY rises as soon as a sweep is scheduled and falls one cycle after the last sweep write
    busy_d = (state_d == ST_SWEEP) || (state_q == ST_SWEEP);
    drop_d = (drop_inc && (drop_q != {DROP_W{1'b1}})) ? drop_q + 1'b1 : drop_q;
  end

  assign bus.X_COORD  = x_q;
  assign bus.Y_COORD  = y_q;
  assign bus.VALUE    = v_q;
  assign bus.W_EN     = wen_q;
  assign bus.BUSY     = busy_q;
  assign bus.DROP_CNT = drop_q;

endmodule
`default_nettype wire
